wireless_cfg_tx: RTL and testbench

WIRELESS_CFG_TX -- requirements
Module: wireless_cfg_tx

---
 rtl/wireless_pkg.sv | 34 +++
 rtl/wireless_cfg_tx_uart_tx.sv | 82 ++++++++
 rtl/wireless_cfg_tx.sv | 122 ++++++++++++
 tb/tb_wireless_cfg_tx.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wireless_pkg.sv
// wireless_pkg: shared types and constants for the wireless module configuration sender.
// Optional feature macro: WIRELESS_CFG_TX_PARITY_EN (adds an even-parity bit to each UART frame).
package wireless_pkg;

  // Transaction sequencer states.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRE_GUARD  = 3'd1,
    SEND       = 3'd2,
    POST_GUARD = 3'd3,
    FINISH     = 3'd4
  } wireless_cfg_state_t;

  // Level of the UART line when nothing is being sent.
  localparam logic UART_IDLE = 1'b1;

  localparam int DEFAULT_CLK_FREQ     = 100_000_000;
  localparam int DEFAULT_BAUD         = 9600;
  localparam int DEFAULT_GUARD_CYCLES = 4_000_000;

`ifdef WIRELESS_CFG_TX_PARITY_EN
  // start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;
`else
  // start + 8 data + stop
  localparam int FRAME_BITS = 10;
`endif

  // Width of a counter that must hold 0 .. n_values-1 (at least one bit).
  function automatic int cnt_width(input int n_values);
    return (n_values > 1) ? $clog2(n_values) : 1;
  endfunction

endpackage

// File: rtl/wireless_cfg_tx_uart_tx.sv
// uart_tx: generic byte serializer, LSB first, DIV clock cycles per bit.
// Frame is 8N1, or 8E1 when WIRELESS_CFG_TX_PARITY_EN is defined.
// Handshake: a byte is taken on any cycle where valid && ready. ready is high while
// idle and also on the final cycle of the stop bit, so a sender holding valid gets
// frames with no idle gap between them. The start bit drives txd on the cycle after
// the accept.
module uart_tx
  import wireless_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       txd
);

  localparam int CW = cnt_width(DIV);
  localparam int BW = cnt_width(FRAME_BITS);
  localparam int SW = FRAME_BITS - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);

  logic          r_busy;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic [SW-1:0] r_shift;
  logic          r_txd;

  logic          w_bit_end;
  logic          w_frame_end;
  logic          w_accept;
  logic [SW-1:0] w_load;

  assign w_bit_end   = (r_cnt == CNT_LAST);
  assign w_frame_end = w_bit_end && (r_bit == BIT_LAST);
  assign ready       = !r_busy || w_frame_end;
  assign w_accept    = valid && ready;
  assign txd         = r_txd;

  // Bits after the start bit, in transmit order from bit 0 upward.
`ifdef WIRELESS_CFG_TX_PARITY_EN
  assign w_load = {1'b1, ^data, data};
`else
  assign w_load = {1'b1, data};
`endif

  // Bit timer and shifter; a new accept always wins over finishing the stop bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= UART_IDLE;
    end else if (w_accept) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= w_load;
      r_txd   <= 1'b0;
    end else if (r_busy) begin
      if (w_bit_end) begin
        r_cnt <= '0;
        if (r_bit == BIT_LAST) begin
          r_busy <= 1'b0;
          r_bit  <= '0;
          r_txd  <= UART_IDLE;
        end else begin
          r_bit   <= r_bit + BW'(1);
          r_txd   <= r_shift[0];
          r_shift <= {1'b1, r_shift[SW-1:1]};
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/wireless_cfg_tx.sv
// wireless_cfg_tx: pulls SET low, waits a guard time, streams command bytes over the
// UART, waits a second guard time, then releases SET and pulses done.
// Optional feature macro: WIRELESS_CFG_TX_PARITY_EN (even parity in every frame).
// Handshake: in_data/in_last are taken when in_valid && in_ready; in_ready is only
// offered in SEND, while the serializer can take a byte and before the in_last byte
// has been accepted. o_dbg_state exposes the sequencer state for observation.
module wireless_cfg_tx
  import wireless_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int GUARD_CYCLES = DEFAULT_GUARD_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       wireless_rx,
  output logic       wireless_set,
  output logic       busy,
  output logic       done,
  output logic [2:0] o_dbg_state
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int GW  = cnt_width(GUARD_CYCLES);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);

  wireless_cfg_state_t r_state;
  logic [GW-1:0]       r_guard;
  logic                r_last_acc;
  logic                r_set;
  logic                r_busy;
  logic                r_done;

  logic w_uart_ready;
  logic w_in_ready;
  logic w_accept;

  assign w_in_ready   = (r_state == SEND) && !r_last_acc && w_uart_ready;
  assign w_accept     = in_valid && w_in_ready;
  assign in_ready     = w_in_ready;
  assign wireless_set = r_set;
  assign busy         = r_busy;
  assign done         = r_done;
  assign o_dbg_state  = r_state;

  uart_tx #(
    .DIV(DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst  (rst),
    .data (in_data),
    .valid(w_accept),
    .ready(w_uart_ready),
    .txd  (wireless_rx)
  );

  // Sequencer with guard counter; SET, busy and done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_guard    <= '0;
      r_last_acc <= 1'b0;
      r_set      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= PRE_GUARD;
            r_set      <= 1'b0;
            r_busy     <= 1'b1;
            r_guard    <= '0;
            r_last_acc <= 1'b0;
          end
        end
        PRE_GUARD: begin
          if (r_guard == GUARD_LAST) begin
            r_guard <= '0;
            r_state <= SEND;
          end else begin
            r_guard <= r_guard + GW'(1);
          end
        end
        SEND: begin
          if (w_accept && in_last) begin
            r_last_acc <= 1'b1;
          end
          // With the final byte taken, serializer ready marks its last stop-bit cycle.
          if (r_last_acc && w_uart_ready) begin
            r_last_acc <= 1'b0;
            r_state    <= POST_GUARD;
          end
        end
        POST_GUARD: begin
          if (r_guard == GUARD_LAST) begin
            r_guard <= '0;
            r_state <= FINISH;
            r_set   <= 1'b1;
            r_done  <= 1'b1;
          end else begin
            r_guard <= r_guard + GW'(1);
          end
        end
        FINISH: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wireless_cfg_tx.sv
// tb_wireless_cfg_tx: randomized bench with a transaction-level timing model and a
// scoreboard monitor for UART frames, SET/busy edges, done pulses and in_ready counts.
`timescale 1ns/1ps
module tb_wireless_cfg_tx;

  localparam int CLK_FREQ = 40;
  localparam int BAUD     = 10;
  localparam int G        = 10;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef WIRELESS_CFG_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL        = NB * DIV;
  localparam int ABORT_LEN = 4 * DIV + 2;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic       wireless_rx;
  logic       wireless_set;
  logic       busy;
  logic       done;
  logic [2:0] dbg_state;

  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  wireless_cfg_tx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .GUARD_CYCLES(G)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .wireless_rx (wireless_rx),
    .wireless_set(wireless_set),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation ran past its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard queues ----------------
  logic [55:0] exp_frame_q[$];  // {len_cycles16, start_cycle32, data8}
  logic [32:0] exp_set_q[$];    // {level, cycle}
  logic [32:0] exp_busy_q[$];   // {level, cycle}
  logic [31:0] exp_done_q[$];   // cycle of done pulse
  logic [31:0] exp_rdy_q[$];    // in_ready-high cycles per completed transaction
  logic [7:0]  tx_bytes[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Line level of frame bit k for byte d.
  function automatic logic exp_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
`ifdef WIRELESS_CFG_TX_PARITY_EN
    if (k == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // ---------------- monitor ----------------
  bit          mon_en = 0;
  logic        p_set = 1'b1;
  logic        p_busy = 1'b0;
  logic        p_rx = 1'b1;
  bit          in_frame = 0;
  int          fidx = 0;
  int          flen = 0;
  int          fbad = 0;
  logic [7:0]  fdata = 8'd0;
  int          rdy_cnt = 0;

  always @(negedge clk) begin
    logic [55:0] f;
    logic [32:0] e;
    logic [31:0] q;
    if (mon_en) begin
      if (rst) rdy_cnt = 0;
      else if (in_ready === 1'b1) rdy_cnt++;

      if (wireless_set !== p_set) begin
        if (exp_set_q.size() == 0) unexpected("set_edge");
        else begin
          e = exp_set_q.pop_front();
          check("set_level", 64'(wireless_set), 64'(e[32]));
          check("set_edge_cycle", 64'(cyc), 64'(e[31:0]));
        end
      end

      if (busy !== p_busy) begin
        if (exp_busy_q.size() == 0) unexpected("busy_edge");
        else begin
          e = exp_busy_q.pop_front();
          check("busy_level", 64'(busy), 64'(e[32]));
          check("busy_edge_cycle", 64'(cyc), 64'(e[31:0]));
        end
      end

      if (done !== 1'b0) begin
        if (exp_done_q.size() == 0) unexpected("done_pulse");
        else begin
          q = exp_done_q.pop_front();
          check("done_cycle", 64'(cyc), 64'(q));
        end
        if (exp_rdy_q.size() == 0) unexpected("in_ready_count");
        else begin
          q = exp_rdy_q.pop_front();
          check("in_ready_cycles", 64'(rdy_cnt), 64'(q));
        end
        rdy_cnt = 0;
      end

      if (!in_frame && p_rx === 1'b1 && wireless_rx === 1'b0) begin
        if (exp_frame_q.size() == 0) unexpected("frame_start");
        else begin
          f = exp_frame_q.pop_front();
          flen  = int'(f[55:40]);
          fdata = f[7:0];
          check("frame_start_cycle", 64'(cyc), 64'(f[39:8]));
          in_frame = 1;
          fidx = 0;
          fbad = 0;
        end
      end
      if (in_frame) begin
        if (wireless_rx !== exp_bit(fdata, fidx / DIV)) fbad++;
        fidx++;
        if (fidx == flen) begin
          check("frame_bad_samples", 64'(fbad), 64'd0);
          in_frame = 0;
        end
      end
    end
    p_set  = wireless_set;
    p_busy = busy;
    p_rx   = wireless_rx;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx"}, 64'(wireless_rx), 64'd1);
    check({tag, "_set"}, 64'(wireless_set), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'(3'(wireless_pkg::IDLE)));
  endtask

  // One configuration transaction. Timing model: start seen at cycle s => SET low
  // from s+1, SEND from s+1+G; a byte offered at cycle v is taken at
  // max(v, engine free), its frame starts one cycle later and frees the engine
  // FL cycles after the take; the final frame is followed by G guard cycles and
  // then the FINISH cycle.
  task automatic run_txn(input int nb, input int idle_wait, input bit pokes,
                         input bit abort, input bit fin_start);
    int s, ready_t, a, rdy_exp, fin;
    logic [7:0] d;
    bit got;
    s = cyc;
    a = 0;
    exp_set_q.push_back({1'b0, 32'(s + 1)});
    exp_busy_q.push_back({1'b1, 32'(s + 1)});
    start = 1'b1;
    step();
    start = 1'b0;
    if (pokes) begin
      wait_until(s + 1 + G / 2);
      start = 1'b1;
      step();
      start = 1'b0;
    end
    ready_t = s + 1 + G;
    wait_until(ready_t + idle_wait);
    rdy_exp = 0;
    for (int i = 0; i < nb; i++) begin
      d = (tx_bytes.size() > 0) ? tx_bytes.pop_front() : 8'($urandom_range(0, 255));
      in_data  = d;
      in_valid = 1'b1;
      in_last  = (i == nb - 1);
      a = (cyc > ready_t) ? cyc : ready_t;
      rdy_exp += a - ready_t + 1;
      exp_frame_q.push_back({16'(abort ? ABORT_LEN : FL), 32'(a + 1), d});
      ready_t = a + FL;
      got = 0;
      for (int k = 0; k < 4 * FL && !got; k++) begin
        @(negedge clk);
        if (in_ready === 1'b1) got = 1;
      end
      check("handshake_taken", 64'(got), 64'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (abort) begin
      wait_until(a + ABORT_LEN);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_set_q.push_back({1'b1, 32'(cyc)});
      exp_busy_q.push_back({1'b0, 32'(cyc)});
      @(negedge clk);
      check_reset_outputs("abort");
      step();
      return;
    end
    if (pokes) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    fin = a + FL + 1 + G;
    exp_set_q.push_back({1'b1, 32'(fin)});
    exp_done_q.push_back(32'(fin));
    exp_rdy_q.push_back(32'(rdy_exp));
    exp_busy_q.push_back({1'b0, 32'(fin + 1)});
    if (fin_start) begin
      wait_until(fin);
      start = 1'b1;
      step();
    end else begin
      wait_until(fin + 2 + int'($urandom_range(0, 3)));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_data  = 8'd0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    mon_en = 1;

    tx_bytes.push_back(8'h41);
    run_txn(1, 0, 0, 0, 0);

    tx_bytes.push_back(8'h41);
    tx_bytes.push_back(8'h54);
    run_txn(2, 0, 0, 0, 0);

    tx_bytes.push_back(8'h41);
    tx_bytes.push_back(8'h43);
    run_txn(2, 0, 0, 0, 0);

    run_txn(1, 50, 0, 0, 0);
    run_txn(2, 0, 1, 0, 0);
    run_txn(1, 0, 0, 0, 1);
    run_txn(1, 0, 0, 0, 0);

    tx_bytes.push_back(8'hA5);
    run_txn(1, 0, 0, 1, 0);
    tx_bytes.push_back(8'h41);
    run_txn(1, 0, 0, 0, 0);

    for (int t = 0; t < 6; t++) begin
      run_txn(int'($urandom_range(1, 3)), int'($urandom_range(0, 5)), 0, 0, 0);
    end

    repeat (5) step();
    check("frames_left", 64'(exp_frame_q.size()), 64'd0);
    check("set_edges_left", 64'(exp_set_q.size()), 64'd0);
    check("busy_edges_left", 64'(exp_busy_q.size()), 64'd0);
    check("done_pulses_left", 64'(exp_done_q.size()), 64'd0);
    check("ready_counts_left", 64'(exp_rdy_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
